// File: rtl/cb_cfg_pkg.sv
// Shared types and helpers for the connection-block frame config loader.
// Optional CRC stage is enabled by defining CONFIG_CRC_EN.
package cb_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CHECK,
    DONE
  } cfg_state_e;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // 4-bit per-mem bit counts, entry 0 in the LSBs
  localparam logic [63:0] DEF_MEM_SIZES = 64'h0000_0626_6666_6666;

  function automatic int mem_size(input logic [63:0] sizes, input int m);
    return int'(sizes[m*4 +: 4]);
  endfunction

  function automatic int total_bits(input logic [63:0] sizes, input int n);
    int t;
    t = 0;
    for (int i = 0; i < 16; i++) begin
      if (i < n) t += mem_size(sizes, i);
    end
    return t;
  endfunction

endpackage

// File: rtl/cb_cfg_crc16.sv
// Serial CRC-16-CCITT over a bit stream, MSB-first shift.
// Used by the loader only when CONFIG_CRC_EN is defined.
module cb_cfg_crc16
  import cb_cfg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear) begin
      crc_d = CRC16_INIT;
    end else if (en) begin
      crc_d = {crc_q[14:0], 1'b0} ^
              ((crc_q[15] ^ bit_in) ? CRC16_POLY : 16'h0000);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) crc_q <= CRC16_INIT;
    else     crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/cb_frame_config_loader.sv
// Walks a serial config stream into decoder-addressed CB mem writes.
// Define CONFIG_CRC_EN to add a trailing CRC-16 check stage.
module cb_frame_config_loader
  import cb_cfg_pkg::*;
#(
  parameter int          BIT_AW    = 3,
  parameter int          MEM_AW    = 4,
  parameter int          NUM_MEMS  = 11,
  parameter logic [63:0] MEM_SIZES = DEF_MEM_SIZES
) (
  input  logic                     prog_clk,
  input  logic                     pReset,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     bit_valid,
  input  logic                     bit_data,
  input  logic                     bit_last,
  output logic                     bit_ready,
  output logic                     enable,
  output logic [BIT_AW+MEM_AW-1:0] address,
  output logic                     data_in,
  output logic                     busy,
  output logic                     done,
  output logic                     len_err,
  output logic                     crc_err
);

  localparam int TOTAL = total_bits(MEM_SIZES, NUM_MEMS);
  localparam int CW    = BIT_AW + MEM_AW + 2;

  cfg_state_e state_q, state_d;
  logic [BIT_AW-1:0]        bit_idx_q, bit_idx_d;
  logic [MEM_AW-1:0]        mem_idx_q, mem_idx_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [BIT_AW+MEM_AW-1:0] addr_q, addr_d;
  logic enable_q, enable_d;
  logic data_q, data_d;
  logic len_err_q, len_err_d;
  logic accept, mem_end, cfg_end;

`ifdef CONFIG_CRC_EN
  logic [14:0] rx_q, rx_d;
  logic [15:0] crc_val;
  logic crc_err_q, crc_err_d;
  logic crc_clr, crc_en;
`endif

  assign bit_ready = (state_q == LOAD) || (state_q == CHECK);
  assign accept    = bit_valid && bit_ready;
  assign mem_end   = int'(bit_idx_q) ==
                     mem_size(MEM_SIZES, int'(mem_idx_q)) - 1;
  assign cfg_end   = int'(cnt_q) == TOTAL - 1;

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    mem_idx_d = mem_idx_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    enable_d  = 1'b0;
    len_err_d = len_err_q;
`ifdef CONFIG_CRC_EN
    rx_d      = rx_q;
    crc_err_d = crc_err_q;
    crc_clr   = 1'b0;
    crc_en    = 1'b0;
`endif
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d   = LOAD;
            bit_idx_d = '0;
            mem_idx_d = '0;
            cnt_d     = '0;
            len_err_d = 1'b0;
`ifdef CONFIG_CRC_EN
            crc_err_d = 1'b0;
            crc_clr   = 1'b1;
`endif
          end
        end
        LOAD: begin
          if (accept) begin
            enable_d = 1'b1;
            addr_d   = {bit_idx_q, mem_idx_q};
            data_d   = bit_data;
            cnt_d    = cnt_q + 1'b1;
`ifdef CONFIG_CRC_EN
            crc_en   = 1'b1;
`endif
            if (mem_end) begin
              bit_idx_d = '0;
              mem_idx_d = mem_idx_q + 1'b1;
            end else begin
              bit_idx_d = bit_idx_q + 1'b1;
            end
            if (cfg_end) begin
`ifdef CONFIG_CRC_EN
              // last must come with the final CRC bit, not the final cfg bit
              if (bit_last) begin
                len_err_d = 1'b1;
                state_d   = DONE;
              end else begin
                rx_d    = '0;
                state_d = CHECK;
              end
`else
              if (!bit_last) len_err_d = 1'b1;
              state_d = DONE;
`endif
            end else if (bit_last) begin
              len_err_d = 1'b1;
              state_d   = DONE;
            end
          end
        end
        CHECK: begin
`ifdef CONFIG_CRC_EN
          if (accept) begin
            cnt_d = cnt_q + 1'b1;
            rx_d  = {rx_q[13:0], bit_data};
            if (int'(cnt_q) == TOTAL + 15) begin
              crc_err_d = ({rx_q, bit_data} != crc_val);
              if (!bit_last) len_err_d = 1'b1;
              state_d = DONE;
            end else if (bit_last) begin
              len_err_d = 1'b1;
              state_d   = DONE;
            end
          end
`else
          state_d = IDLE;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q   <= IDLE;
      bit_idx_q <= '0;
      mem_idx_q <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= 1'b0;
      enable_q  <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      mem_idx_q <= mem_idx_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      enable_q  <= enable_d;
      len_err_q <= len_err_d;
    end
  end

`ifdef CONFIG_CRC_EN
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      rx_q      <= '0;
      crc_err_q <= 1'b0;
    end else begin
      rx_q      <= rx_d;
      crc_err_q <= crc_err_d;
    end
  end

  cb_cfg_crc16 u_crc (
    .clk    (prog_clk),
    .rst    (pReset),
    .clear  (crc_clr),
    .en     (crc_en),
    .bit_in (bit_data),
    .crc    (crc_val)
  );

  assign crc_err = crc_err_q;
`else
  assign crc_err = 1'b0;
`endif

  assign enable  = enable_q;
  assign address = addr_q;
  assign data_in = data_q;
  assign busy    = bit_ready;
  assign done    = (state_q == DONE);
  assign len_err = len_err_q;

endmodule
